// File: rtl/addsub_arb_pkg.sv
// Shared definitions for the round-robin adder/subtractor arbiter:
// FSM state type, datapath width, requester limit and an overflow helper.
package addsub_arb_pkg;

    localparam int ADDSUB_W = 4;
    localparam int NREQ_MAX = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Two's-complement overflow of a 4-bit add (sel=0) or subtract (sel=1).
    function automatic logic signed_ovf(
        input logic [ADDSUB_W-1:0] a,
        input logic [ADDSUB_W-1:0] b,
        input logic [ADDSUB_W-1:0] s,
        input logic                sel
    );
        logic msb_a;
        logic msb_b;
        logic msb_s;
        msb_a = a[ADDSUB_W-1];
        msb_b = b[ADDSUB_W-1];
        msb_s = s[ADDSUB_W-1];
        if (sel)
            return (msb_a != msb_b) && (msb_s != msb_a);
        else
            return (msb_a == msb_b) && (msb_s != msb_a);
    endfunction

endpackage

// File: rtl/adder_subtractor_4bit.sv
// Shared nibble datapath: S = A + B (sel=0) or S = A + ~B + 1 (sel=1),
// cout is the carry out of that sum (for subtract, 1 = no borrow).
module adder_subtractor_4bit
    import addsub_arb_pkg::*;
(
    input  logic [ADDSUB_W-1:0] a,
    input  logic [ADDSUB_W-1:0] b,
    input  logic                sel,
    output logic [ADDSUB_W-1:0] s,
    output logic                cout
);

    logic [ADDSUB_W-1:0] b_eff;

    // Invert B and inject a carry-in of 1 for subtraction.
    always_comb begin
        b_eff     = b ^ {ADDSUB_W{sel}};
        {cout, s} = (ADDSUB_W+1)'(a) + (ADDSUB_W+1)'(b_eff) + (ADDSUB_W+1)'(sel);
    end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above rr_ptr,
// wrapping modulo NREQ. Produces a one-hot grant and its encoded index.
module rr_arbiter
    import addsub_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int PTR_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [NREQ-1:0]  gnt_oh,
    output logic [PTR_W-1:0] gnt_idx
);

    logic             found;
    logic [PTR_W-1:0] idx;

    // Walk the requesters starting at rr_ptr and keep the first hit.
    always_comb begin
        // NOTE: every output of a combinational block is given a default first,
        // so no path leaves it unassigned and no latch is inferred.
        gnt_oh  = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = PTR_W'((int'(rr_ptr) + k) % NREQ);
            if (!found && req[idx]) begin
                found       = 1'b1;
                gnt_oh[idx] = 1'b1;
                gnt_idx     = idx;
            end
        end
    end

endmodule

// File: rtl/adder_subtractor_arbiter.sv
// Round-robin front end sharing one adder_subtractor_4bit between NREQ
// requesters. FSM IDLE -> EXEC -> RESP, one operation per 3 cycles at best.
// Optional macro ADDSUB_ARB_OVF_EN adds the rsp_ovf signed-overflow output.
module adder_subtractor_arbiter
    import addsub_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [ADDSUB_W*NREQ-1:0] req_a,
    input  logic [ADDSUB_W*NREQ-1:0] req_b,
    input  logic [NREQ-1:0]          req_sel,
    output logic [NREQ-1:0]          rsp_valid,
    input  logic [NREQ-1:0]          rsp_ready,
    output logic [ADDSUB_W-1:0]      rsp_s,
`ifdef ADDSUB_ARB_OVF_EN
    output logic                     rsp_ovf,
`endif
    output logic                     rsp_cout
);

    localparam int PTR_W = $clog2(NREQ);

    state_e              state_q,    state_d;
    logic [PTR_W-1:0]    rr_ptr_q,   rr_ptr_d;
    logic [PTR_W-1:0]    gnt_q,      gnt_d;
    logic [ADDSUB_W-1:0] op_a_q,     op_a_d;
    logic [ADDSUB_W-1:0] op_b_q,     op_b_d;
    logic                op_sel_q,   op_sel_d;
    logic [ADDSUB_W-1:0] res_s_q,    res_s_d;
    logic                res_cout_q, res_cout_d;

    logic [NREQ-1:0]     arb_oh;
    logic [PTR_W-1:0]    arb_idx;
    logic [ADDSUB_W-1:0] alu_s;
    logic                alu_cout;

    rr_arbiter #(.NREQ(NREQ), .PTR_W(PTR_W)) u_rr_arbiter (
        .req     (req_valid),
        .rr_ptr  (rr_ptr_q),
        .gnt_oh  (arb_oh),
        .gnt_idx (arb_idx)
    );

    adder_subtractor_4bit u_addsub (
        .a    (op_a_q),
        .b    (op_b_q),
        .sel  (op_sel_q),
        .s    (alu_s),
        .cout (alu_cout)
    );

    // Next-state logic: accept the arbiter winner, compute, then hold the result.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        gnt_d      = gnt_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        op_sel_d   = op_sel_q;
        res_s_d    = res_s_q;
        res_cout_d = res_cout_q;
        case (state_q)
            ST_IDLE: begin
                if (|arb_oh) begin
                    for (int i = 0; i < NREQ; i++) begin
                        if (arb_oh[i]) begin
                            op_a_d   = req_a[i*ADDSUB_W +: ADDSUB_W];
                            op_b_d   = req_b[i*ADDSUB_W +: ADDSUB_W];
                            op_sel_d = req_sel[i];
                        end
                    end
                    gnt_d    = arb_idx;
                    rr_ptr_d = (arb_idx == PTR_W'(NREQ-1)) ? '0 : arb_idx + PTR_W'(1);
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                res_s_d    = alu_s;
                res_cout_d = alu_cout;
                state_d    = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready[gnt_q]) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: clocked state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            gnt_q      <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_sel_q   <= 1'b0;
            res_s_q    <= '0;
            res_cout_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            gnt_q      <= gnt_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            op_sel_q   <= op_sel_d;
            res_s_q    <= res_s_d;
            res_cout_q <= res_cout_d;
        end
    end

`ifdef ADDSUB_ARB_OVF_EN
    logic res_ovf_q;

    // Signed overflow captured alongside the result.
    always_ff @(posedge clk) begin
        if (!rst_n)
            res_ovf_q <= 1'b0;
        else if (state_q == ST_EXEC)
            res_ovf_q <= signed_ovf(op_a_q, op_b_q, alu_s, op_sel_q);
    end

    assign rsp_ovf = res_ovf_q;
`endif

    // Handshake outputs; both are forced low throughout a reset cycle.
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        if (rst_n && state_q == ST_IDLE) req_ready = arb_oh;
        if (rst_n && state_q == ST_RESP) rsp_valid = NREQ'(1) << gnt_q;
    end

    assign rsp_s    = res_s_q;
    assign rsp_cout = res_cout_q;

endmodule

// File: tb/tb_adder_subtractor_arbiter.sv
// Self-checking bench for adder_subtractor_arbiter (NREQ=4): directed test
// vectors plus randomized rounds against a plain-arithmetic reference model.
// Define ADDSUB_ARB_OVF_EN to also check rsp_ovf.
module tb_adder_subtractor_arbiter;

    localparam int NREQ = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NREQ-1:0] req_valid;
    logic [NREQ-1:0] req_ready;
    logic [4*NREQ-1:0] req_a;
    logic [4*NREQ-1:0] req_b;
    logic [NREQ-1:0] req_sel;
    logic [NREQ-1:0] rsp_valid;
    logic [NREQ-1:0] rsp_ready;
    logic [3:0]      rsp_s;
    logic            rsp_cout;
`ifdef ADDSUB_ARB_OVF_EN
    logic            rsp_ovf;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: operands per requester and round-robin pointer.
    logic [3:0] m_a   [NREQ];
    logic [3:0] m_b   [NREQ];
    logic       m_sel [NREQ];
    int         m_ptr;

    always #5 clk = ~clk;

    adder_subtractor_arbiter #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sel   (req_sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_s     (rsp_s),
`ifdef ADDSUB_ARB_OVF_EN
        .rsp_ovf   (rsp_ovf),
`endif
        .rsp_cout  (rsp_cout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // First valid requester at or after ptr, wrapping; -1 if none.
    function automatic int pick(input logic [NREQ-1:0] v, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic pack_ops();
        for (int i = 0; i < NREQ; i++) begin
            req_a[4*i +: 4] = m_a[i];
            req_b[4*i +: 4] = m_b[i];
            req_sel[i]      = m_sel[i];
        end
    endtask

    task automatic set_op(input int r, input int a, input int b, input logic sel);
        m_a[r]   = 4'(a);
        m_b[r]   = 4'(b);
        m_sel[r] = sel;
    endtask

    // Called at a negedge; leaves the bench at the negedge after reset is released.
    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        @(negedge clk);
        rst_n = 1'b1;
        m_ptr = 0;
    endtask

    // One arbitration round starting with the DUT in IDLE at a negedge.
    // hold = number of RESP cycles with the winner's rsp_ready low.
    task automatic run_round(input logic [NREQ-1:0] vld, input int hold);
        int g, a, b, sa, sb, r, e_s, e_c, e_o;
        logic [NREQ-1:0] noise;
        g         = pick(vld, m_ptr);
        req_valid = vld;
        rsp_ready = '0;
        pack_ops();
        #1;
        if (g < 0) begin
            check("idle_req_ready", 32'(req_ready), 0);
            check("idle_rsp_valid", 32'(rsp_valid), 0);
            @(negedge clk);
            return;
        end
        check("req_ready_grant", 32'(req_ready), 32'(1) << g);

        a = int'(m_a[g]);
        b = int'(m_b[g]);
        if (m_sel[g]) begin
            e_s = (a - b + 16) % 16;
            e_c = (a >= b) ? 1 : 0;
        end else begin
            e_s = (a + b) % 16;
            e_c = (a + b >= 16) ? 1 : 0;
        end
        sa  = (a >= 8) ? a - 16 : a;
        sb  = (b >= 8) ? b - 16 : b;
        r   = m_sel[g] ? sa - sb : sa + sb;
        e_o = (r < -8 || r > 7) ? 1 : 0;
        m_ptr = (g + 1) % NREQ;

        @(negedge clk);
        #1;
        check("exec_rsp_valid", 32'(rsp_valid), 0);
        check("exec_req_ready", 32'(req_ready), 0);

        @(negedge clk);
        for (int h = 0; h <= hold; h++) begin
            noise     = NREQ'($urandom);
            rsp_ready = (h < hold) ? (noise & ~(NREQ'(1) << g)) : (noise | (NREQ'(1) << g));
            #1;
            check("rsp_valid", 32'(rsp_valid), 32'(1) << g);
            check("rsp_s", 32'(rsp_s), 32'(e_s));
            check("rsp_cout", 32'(rsp_cout), 32'(e_c));
`ifdef ADDSUB_ARB_OVF_EN
            check("rsp_ovf", 32'(rsp_ovf), 32'(e_o));
`endif
            check("resp_req_ready", 32'(req_ready), 0);
            @(negedge clk);
        end
        rsp_ready = '0;
        req_valid = '0;
    endtask

    initial begin
        int g;
        rst_n = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        for (int i = 0; i < NREQ; i++) set_op(i, 0, 0, 1'b0);
        pack_ops();
        m_ptr = 0;
        @(negedge clk);

        // Reset state: nothing offered or presented while rst_n is low.
        req_valid = '1;
        #1;
        check("reset_req_ready", 32'(req_ready), 0);
        check("reset_rsp_valid", 32'(rsp_valid), 0);
        do_reset();
        check("reset_rsp_s", 32'(rsp_s), 0);
        check("reset_rsp_cout", 32'(rsp_cout), 0);

        // Directed arithmetic cases.
        set_op(0, 4, 4, 1'b0);   run_round(4'b0001, 0);
        set_op(1, 4, 13, 1'b0);  run_round(4'b0010, 0);
        set_op(2, 13, 12, 1'b1); run_round(4'b0100, 0);
        set_op(3, 4, 4, 1'b1);   run_round(4'b1000, 0);
        set_op(0, 7, 1, 1'b0);   run_round(4'b0001, 0);
        set_op(1, 8, 1, 1'b1);   run_round(4'b0010, 0);
        set_op(2, 4, 4, 1'b0);   run_round(4'b0100, 0);
        set_op(3, 0, 1, 1'b1);   run_round(4'b1000, 0);

        // All requesters valid after reset: order 0,1,2,3 then wrap to 0.
        do_reset();
        for (int i = 0; i < NREQ; i++) set_op(i, i + 3, 2 * i + 1, i[0]);
        for (int n = 0; n < NREQ + 1; n++) run_round(4'b1111, 0);

        // Stalled response with everyone else still requesting.
        run_round(4'b1111, 5);
        run_round(4'b1111, 0);

        // Reset while in RESP drops the pending response.
        set_op(2, 9, 5, 1'b0);
        g = pick(4'b0100, m_ptr);
        req_valid = 4'b0100;
        pack_ops();
        @(negedge clk);
        @(negedge clk);
        #1;
        check("pre_reset_rsp_valid", 32'(rsp_valid), 32'(1) << g);
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        rsp_ready = 4'b1111;
        #1;
        check("rst_resp_rsp_valid", 32'(rsp_valid), 0);
        check("rst_resp_req_ready", 32'(req_ready), 0);
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = '0;
        rsp_ready = '0;
        m_ptr     = 0;
        for (int n = 0; n < 4; n++) begin
            #1;
            check("post_reset_rsp_valid", 32'(rsp_valid), 0);
            @(negedge clk);
        end
        run_round(4'b1111, 0);

        // Randomized traffic.
        for (int n = 0; n < 80; n++) begin
            for (int i = 0; i < NREQ; i++)
                set_op(i, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'($urandom));
            run_round(($urandom_range(0, 4) == 0) ? 4'b0000 : 4'($urandom),
                      int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
